// File: rtl/ibus_responder_if.sv
// rtl/ibus_responder_if.sv - fetch-side and memory-side signal bundle for ibus_responder
interface ibus_responder_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int BLOCK_WORDS = 2
);
  logic                     ireq_valid;
  logic [63:0]              ireq_pc;
  logic                     flush;
  logic [FETCH_WIDTH-1:0]   iresp_valid;
  logic [FETCH_WIDTH*32-1:0] iresp_raw;
  logic                     busy;
  logic                     mreq_valid;
  logic [63:0]              mreq_addr;
  logic                     mreq_ready;
  logic                     mresp_valid;
  logic [32*BLOCK_WORDS-1:0] mresp_data;

  modport slave (
    input  ireq_valid, ireq_pc, flush, mreq_ready, mresp_valid, mresp_data,
    output iresp_valid, iresp_raw, busy, mreq_valid, mreq_addr
  );

  modport master (
    output ireq_valid, ireq_pc, flush, mreq_ready, mresp_valid, mresp_data,
    input  iresp_valid, iresp_raw, busy, mreq_valid, mreq_addr
  );
endinterface

// File: rtl/ibus_responder.sv
// rtl/ibus_responder.sv - instruction-bus line-buffer responder with single-outstanding miss fill
// Optional feature: define IBUS_FORWARD_EN to forward fill data to fetch in the response cycle.
module ibus_responder #(
  parameter int FETCH_WIDTH = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic            clk,
  input  logic            reset,
  ibus_responder_if.slave bus
);
  localparam int OB = $clog2(4 * BLOCK_WORDS);
  localparam int WB = OB - 2;
  localparam int IW = WB + 1;
  localparam int TW = 64 - OB;
  localparam logic [IW-1:0] BW_LIM = IW'(BLOCK_WORDS);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t                       state, state_next;
  logic                         buf_valid, buf_valid_next;
  logic [TW-1:0]                buf_tag, pend_tag, req_tag;
  logic [BLOCK_WORDS-1:0][31:0] buf_data, src_data;
  logic                         hit, fill, load_pend, src_ok;
  logic                         unused_pc_bits;

  assign req_tag        = bus.ireq_pc[63:OB];
  assign hit            = bus.ireq_valid & buf_valid & (req_tag == buf_tag);
  assign bus.busy       = (state != IDLE);
  assign bus.mreq_valid = (state == REQ);
  assign bus.mreq_addr  = (state == REQ) ? {pend_tag, {OB{1'b0}}} : '0;
  assign unused_pc_bits = ^bus.ireq_pc[1:0];

  // Response source: the line buffer, or the arriving fill when forwarding is built in.
  always_comb begin
    src_data = buf_data;
    src_ok   = hit;
`ifdef IBUS_FORWARD_EN
    if (state == WAIT && bus.mresp_valid && !bus.flush && bus.ireq_valid &&
        req_tag == pend_tag) begin
      src_data = bus.mresp_data;
      src_ok   = 1'b1;
    end
`endif
  end

  // Slots stop at the block boundary; they never wrap into the next block.
  always_comb begin
    bus.iresp_valid = '0;
    bus.iresp_raw   = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      logic [IW-1:0] widx;
      widx = {1'b0, bus.ireq_pc[OB-1:2]} + IW'(i);
      if (src_ok && !bus.flush && widx < BW_LIM) begin
        bus.iresp_valid[i]       = 1'b1;
        bus.iresp_raw[32*i +: 32] = src_data[widx[WB-1:0]];
      end
    end
  end

  always_comb begin
    state_next     = state;
    buf_valid_next = buf_valid;
    fill           = 1'b0;
    load_pend      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ireq_valid && !hit && !bus.flush) begin
          load_pend  = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.flush)           state_next = IDLE;
        else if (bus.mreq_ready) state_next = WAIT;
      end
      WAIT: begin
        if (bus.mresp_valid) begin
          fill           = !bus.flush;
          buf_valid_next = 1'b1;
          state_next     = IDLE;
        end else if (bus.flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mresp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) buf_valid_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      pend_tag  <= '0;
      buf_data  <= '0;
    end else begin
      state     <= state_next;
      buf_valid <= buf_valid_next;
      if (load_pend) pend_tag <= req_tag;
      if (fill) begin
        buf_data <= bus.mresp_data;
        buf_tag  <= pend_tag;
      end
    end
  end
endmodule

// File: doc/ibus_responder.md
# ibus_responder

Instruction-bus responder on the far side of the fetch stage's `pc` / `iresp` pair. It holds one aligned instruction block in a line buffer and answers hits combinationally with up to FETCH_WIDTH instructions and per-slot valid bits. On a miss it runs a single-outstanding read transaction to the memory side, fills the buffer, and returns data. It sits between the fetch stage and the memory/cache bus and supports a flush for redirects and `fence.i`.

## Interface
- FETCH_WIDTH, 2, instruction slots per response; must be ≤ BLOCK_WORDS.
- BLOCK_WORDS, 2, 32-bit words per block (power of two); block bytes BB = 4*BLOCK_WORDS, offset bits OB = log2(BB).
- clk  in  1  clock; single clock domain, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- ireq_valid  in  1  fetch presents a pc this cycle.
- ireq_pc  in  64  fetch pc; pc[1:0] are always 0.
- flush  in  1  cancels any pending miss and invalidates the buffer.
- iresp_valid  out  FETCH_WIDTH  per-slot valid; slot i holds the instruction at pc+4i.
- iresp_raw  out  FETCH_WIDTH×32  per-slot raw instruction; 0 when the slot is invalid.
- busy  out  1  a miss is in flight (state ≠ IDLE).
- mreq_valid  out  1  memory read request.
- mreq_addr  out  64  block-aligned address: {pc[63:OB], OB'b0}.
- mreq_ready  in  1  memory accepts the request.
- mresp_valid  in  1  read data returned; single beat.
- mresp_data  in  32*BLOCK_WORDS  block data; word w sits at bits [32w+31:32w].

## Operation
- Buffer state: buf_valid, buf_tag[63:OB], buf_data.
- Hit = ireq_valid & buf_valid & (ireq_pc[63:OB] == buf_tag).
- Word index w0 = ireq_pc[OB-1:2]. Slot i is valid iff hit & (w0+i < BLOCK_WORDS); slots never cross into the next block.
  - Example: BLOCK_WORDS=2 with pc[2]=1 gives slot 0 only.
- FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE: if ireq_valid & ~hit & ~flush, latch pend_tag = pc[63:OB] and go to REQ.
  - REQ: mreq_valid=1 with mreq_addr={pend_tag,0}. On mreq_ready go to WAIT. If flush, go to IDLE; no transaction is issued.
  - WAIT: on mresp_valid, write buf_data and buf_tag=pend_tag, set buf_valid=1, go to IDLE. If flush without mresp_valid, go to DRAIN. If flush with mresp_valid in the same cycle, discard the data and go to IDLE.
  - DRAIN: on mresp_valid, discard the data and go to IDLE. The buffer is not written.
- Flush in any state clears buf_valid. Flush also forces iresp_valid=0 in that cycle.
- The fetch stage holds pc steady while iresp_valid is 0. A pc change during REQ/WAIT does not retarget the pending miss; the new pc is looked up after the fill.
- Only one transaction is outstanding. mresp_valid outside WAIT/DRAIN is ignored.

## Timing
- Reset values:
  - state=IDLE, buf_valid=0, pend_tag=0.
  - mreq_valid=0, mreq_addr=0, busy=0, iresp_valid=0, iresp_raw=0.
- Hit latency: 0 cycles; the response is combinational from ireq_pc and the buffer.
- Miss: cycle T detect; T+1 mreq_valid; the request is held until mreq_ready. Data at cycle D → buffer written at the D edge → hit response at D+1 (forwarding disabled).
- mreq_addr is stable while mreq_valid is held.
- Reset mid-miss returns to IDLE with the buffer invalid. A late mresp_valid after reset is ignored, because the FSM is in IDLE.

## Configuration
- IBUS_FORWARD_EN defined:
  - In WAIT with mresp_valid & ~flush & ireq_valid & (ireq_pc[63:OB]==pend_tag), iresp slots are driven from mresp_data in cycle D.
  - Slot rules are the same as for a hit.
  - Miss-to-response latency drops by one cycle.
- Not defined: responses come only from the buffer, earliest at D+1.

## Test plan
- Cold miss: reset, pc=0x80000000, mreq_ready=1, mresp_valid 3 cycles later with data {0x00000513, 0x00100093} → mreq_addr=0x80000000 once. Response:
  - without forwarding: at D+1, valid=2'b11, raw[0]=0x00100093, raw[1]=0x00000513.
  - with IBUS_FORWARD_EN: the same response at cycle D.
- Hit with misaligned slot: after the fill, pc=0x80000004 → valid=2'b01 in the same cycle, raw[0]=0x00000513, no mreq.
- Backpressure: miss with mreq_ready low for 4 cycles → mreq_valid and mreq_addr held constant for 5 cycles, busy=1 throughout.
- Flush in WAIT: flush one cycle after acceptance, then mresp_valid → state DRAIN then IDLE. buf_valid=0, the old pc misses again and issues a new request.
- Flush in REQ: flush before mreq_ready → mreq_valid drops next cycle, FSM in IDLE, no transaction counted.
- Reset mid-WAIT then a stray mresp_valid → no buffer write, iresp_valid=0, busy=0.
